match_scoreboard: RTL and testbench
===================================

// Module: match_scoreboard
// PURPOSE
//   Downstream of the tic-tac-toe game core. Watches the core's win code and nine
//   board cells, and counts X wins, 0 wins and draws across successive games.
//   Holds each result for a display interval, then pulses board_clr so the system
//   clears the board for the next game. Declares a match winner at WIN_TARGET wins.
// PARAMETERS
//   WIN_TARGET   3   game wins needed to take the match (1..2**CNT_W-1)
//   CNT_W        8   width of each score counter
//   HOLD_CYCLES  4   cycles a game result is held before board_clr (>=1)
// PORTS
//   clk           in   1      system clock, rising edge
//   rst           in   1      synchronous active-high reset
//   win           in   2      core win code: 00 none, 01 X wins, 10 0 wins, 11 invalid
//   pos1..pos9    in   2 ea   board cells: 00 empty, 01 X, 10 0, 11 invalid
//   new_match     in   1      1-cycle pulse: clear scores and start a new match
//   score_x       out  CNT_W  X game wins
//   score_o       out  CNT_W  0 game wins
//   score_draw    out  CNT_W  drawn games
//   last_result   out  2      00 none, 01 X, 10 0, 11 draw
//   game_over     out  1      high while not in PLAY
//   board_clr     out  1      1-cycle pulse; the system ORs it into the core rst
//   match_done    out  1      high in MATCH_DONE
//   match_winner  out  2      00 none, 01 X, 10 0; valid while match_done is high
// BEHAVIOUR
//   - Reset (rst=1 at clk edge):
//     - All outputs go to 0 and state goes to PLAY.
//     - rst overrides new_match and every other event.
//   - All outputs are registered.
//   - board_full = all pos cells != 00.
//   - board_empty = all pos cells == 00.
//   - FSM states:
//     - PLAY:
//       - win==01: score_x+1, last_result=01.
//       - win==10: score_o+1, last_result=10.
//       - win==00 and board_full: score_draw+1, last_result=11.
//       - Any of the above goes to RESULT.
//       - win==11 is ignored: no count, stay in PLAY.
//       - Latency: event sampled at edge N, counters and game_over updated at edge N.
//     - RESULT (1 cycle):
//       - score_x==WIN_TARGET: match_winner=01, go to MATCH_DONE.
//       - score_o==WIN_TARGET: match_winner=10, go to MATCH_DONE.
//       - Otherwise load hold counter with HOLD_CYCLES-1 and go to HOLD.
//     - HOLD:
//       - Counter decrements each cycle.
//       - When the counter is 0: board_clr=1 for exactly 1 cycle, go to WAIT_CLR.
//     - WAIT_CLR:
//       - Stays until win==00 and board_empty, then goes to PLAY.
//       - last_result is kept until the next counted game.
//       - This prevents recounting a board that has not been cleared.
//     - MATCH_DONE:
//       - match_done=1.
//       - Scores frozen, win and board ignored.
//       - Stays until new_match.
//   - new_match=1 in any state:
//     - Scores, last_result and match_winner are zeroed.
//     - board_clr pulses 1 cycle.
//     - match_done goes to 0 and state goes to WAIT_CLR.
//     - Has priority over a win or draw detected in the same cycle, which is not counted.
//   - Counters saturate at 2**CNT_W-1; they never wrap.
//   - Draws never count toward WIN_TARGET.
//   - game_over = (state != PLAY).
// TESTING
//   - Reset:
//     - Stimulus: rst high 2 cycles with win=01 applied.
//     - Required: all outputs 0, no count; after release, win=01 gives score_x=1 and
//       game_over=1 one edge later.
//   - Hold and clear (HOLD_CYCLES=4):
//     - Stimulus: win=10 for one cycle, then held at 10.
//     - Required: score_o=1 only, not recounted; board_clr high exactly 1 cycle, 5 cycles
//       after RESULT entry; PLAY re-entered only after win=00 and all cells 00.
//   - Draw:
//     - Stimulus: all cells nonzero with win=00.
//     - Required: score_draw=1, last_result=11, score_x and score_o unchanged.
//   - Match:
//     - Stimulus: X wins 3 games with clears between them.
//     - Required: match_done=1 and match_winner=01; a 4th win=01 is ignored with score_x
//       staying at 3; new_match zeroes the scores and pulses board_clr.
//   - Simultaneous events:
//     - Stimulus: new_match and win=01 in the same cycle while in PLAY.
//     - Required: score_x=0 and board_clr pulses.
//     - Stimulus: win=11.
//     - Required: no state change.
//   - Saturation (CNT_W=2, WIN_TARGET=3):
//     - Stimulus: 5 draws.
//     - Required: score_draw stops at 3 and does not wrap.

Source files
------------

// File: rtl/match_scoreboard.sv
// match_scoreboard
//   Sits downstream of the tic-tac-toe game core. Counts X wins, 0 wins and
//   draws over successive games, holds each result for HOLD_CYCLES, then
//   pulses board_clr so the board is cleared for the next game. The first
//   player to reach WIN_TARGET game wins takes the match.
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   win               core win code: 00 none, 01 X, 10 0, 11 invalid
//   pos1..pos9        board cells: 00 empty, 01 X, 10 0, 11 invalid
//   new_match         1-cycle pulse: clear scores and start a new match
//   score_x/o/draw    saturating game counters
//   last_result       00 none, 01 X, 10 0, 11 draw
//   game_over         high while not in PLAY
//   board_clr         1-cycle pulse, ORed into the core reset by the system
//   match_done        high while the match is decided
//   match_winner      00 none, 01 X, 10 0
module match_scoreboard #(
    parameter int WIN_TARGET  = 3,
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       win,
    input  logic [1:0]       pos1,
    input  logic [1:0]       pos2,
    input  logic [1:0]       pos3,
    input  logic [1:0]       pos4,
    input  logic [1:0]       pos5,
    input  logic [1:0]       pos6,
    input  logic [1:0]       pos7,
    input  logic [1:0]       pos8,
    input  logic [1:0]       pos9,
    input  logic             new_match,
    output logic [CNT_W-1:0] score_x,
    output logic [CNT_W-1:0] score_o,
    output logic [CNT_W-1:0] score_draw,
    output logic [1:0]       last_result,
    output logic             game_over,
    output logic             board_clr,
    output logic             match_done,
    output logic [1:0]       match_winner
);

    localparam int               HC_W      = $clog2(HOLD_CYCLES + 1);
    localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TARGET    = CNT_W'(WIN_TARGET);

    typedef enum logic [2:0] {
        PLAY       = 3'd0,
        RESULT     = 3'd1,
        HOLD       = 3'd2,
        WAIT_CLR   = 3'd3,
        MATCH_DONE = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [HC_W-1:0]  r_hold, w_hold_nxt;
    logic [CNT_W-1:0] r_sx, r_so, r_sd;
    logic [CNT_W-1:0] w_sx_nxt, w_so_nxt, w_sd_nxt;
    logic [1:0]       r_lr, w_lr_nxt;
    logic [1:0]       r_mw, w_mw_nxt;
    logic             r_go, r_bc, r_md;
    logic             w_bc_nxt;
    logic             w_full, w_empty;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign w_full  = (pos1 != 2'b00) && (pos2 != 2'b00) && (pos3 != 2'b00) &&
                     (pos4 != 2'b00) && (pos5 != 2'b00) && (pos6 != 2'b00) &&
                     (pos7 != 2'b00) && (pos8 != 2'b00) && (pos9 != 2'b00);
    assign w_empty = (pos1 == 2'b00) && (pos2 == 2'b00) && (pos3 == 2'b00) &&
                     (pos4 == 2'b00) && (pos5 == 2'b00) && (pos6 == 2'b00) &&
                     (pos7 == 2'b00) && (pos8 == 2'b00) && (pos9 == 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_sx_nxt    = r_sx;
        w_so_nxt    = r_so;
        w_sd_nxt    = r_sd;
        w_lr_nxt    = r_lr;
        w_mw_nxt    = r_mw;
        w_bc_nxt    = 1'b0;

        if (new_match) begin
            // A new match beats any game event seen in the same cycle.
            w_sx_nxt    = '0;
            w_so_nxt    = '0;
            w_sd_nxt    = '0;
            w_lr_nxt    = 2'b00;
            w_mw_nxt    = 2'b00;
            w_bc_nxt    = 1'b1;
            w_state_nxt = WAIT_CLR;
        end else begin
            case (r_state)
                PLAY: begin
                    if (win == 2'b01) begin
                        w_sx_nxt    = sat_inc(r_sx);
                        w_lr_nxt    = 2'b01;
                        w_state_nxt = RESULT;
                    end else if (win == 2'b10) begin
                        w_so_nxt    = sat_inc(r_so);
                        w_lr_nxt    = 2'b10;
                        w_state_nxt = RESULT;
                    end else if (win == 2'b00 && w_full) begin
                        w_sd_nxt    = sat_inc(r_sd);
                        w_lr_nxt    = 2'b11;
                        w_state_nxt = RESULT;
                    end
                end
                RESULT: begin
                    // Scores were already updated on entry, so compare the registers.
                    if (r_sx == TARGET) begin
                        w_mw_nxt    = 2'b01;
                        w_state_nxt = MATCH_DONE;
                    end else if (r_so == TARGET) begin
                        w_mw_nxt    = 2'b10;
                        w_state_nxt = MATCH_DONE;
                    end else begin
                        w_hold_nxt  = HOLD_LOAD;
                        w_state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (r_hold == '0) begin
                        w_bc_nxt    = 1'b1;
                        w_state_nxt = WAIT_CLR;
                    end else begin
                        w_hold_nxt = r_hold - HC_W'(1);
                    end
                end
                WAIT_CLR: begin
                    // Only a fully cleared board re-arms counting, so a stale
                    // result still on the core outputs is never counted twice.
                    if (win == 2'b00 && w_empty) begin
                        w_state_nxt = PLAY;
                    end
                end
                MATCH_DONE: begin
                end
                default: begin
                    w_state_nxt = PLAY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PLAY;
            r_hold  <= '0;
            r_sx    <= '0;
            r_so    <= '0;
            r_sd    <= '0;
            r_lr    <= 2'b00;
            r_mw    <= 2'b00;
            r_go    <= 1'b0;
            r_bc    <= 1'b0;
            r_md    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_sx    <= w_sx_nxt;
            r_so    <= w_so_nxt;
            r_sd    <= w_sd_nxt;
            r_lr    <= w_lr_nxt;
            r_mw    <= w_mw_nxt;
            r_go    <= (w_state_nxt != PLAY);
            r_bc    <= w_bc_nxt;
            r_md    <= (w_state_nxt == MATCH_DONE);
        end
    end

    assign score_x      = r_sx;
    assign score_o      = r_so;
    assign score_draw   = r_sd;
    assign last_result  = r_lr;
    assign game_over    = r_go;
    assign board_clr    = r_bc;
    assign match_done   = r_md;
    assign match_winner = r_mw;

endmodule

// File: tb/tb_match_scoreboard.sv
// Bench for match_scoreboard (CNT_W=2, WIN_TARGET=3, HOLD_CYCLES=4).
// Every change of the output bundle is predicted, with the cycle it must
// appear in, and pushed into a queue; the monitor pops one entry per observed
// change. Unpredicted changes, wrong values, wrong timing and predictions
// that never show up are all reported.
module tb_match_scoreboard;

    localparam int CNT_W       = 2;
    localparam int WIN_TARGET  = 3;
    localparam int HOLD_CYCLES = 4;

    localparam logic [17:0] X_ROW = 18'b000000000000010101;
    localparam logic [17:0] O_ROW = 18'b000000000000101010;
    localparam logic [17:0] FULL  = 18'b010110101001011001;
    localparam logic [17:0] EMPTY = 18'b0;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       win;
    logic [1:0]       pos [9];
    logic             new_match;
    logic [CNT_W-1:0] score_x, score_o, score_draw;
    logic [1:0]       last_result, match_winner;
    logic             game_over, board_clr, match_done;

    always #5 clk = ~clk;

    match_scoreboard #(
        .WIN_TARGET (WIN_TARGET),
        .CNT_W      (CNT_W),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .win         (win),
        .pos1        (pos[0]),
        .pos2        (pos[1]),
        .pos3        (pos[2]),
        .pos4        (pos[3]),
        .pos5        (pos[4]),
        .pos6        (pos[5]),
        .pos7        (pos[6]),
        .pos8        (pos[7]),
        .pos9        (pos[8]),
        .new_match   (new_match),
        .score_x     (score_x),
        .score_o     (score_o),
        .score_draw  (score_draw),
        .last_result (last_result),
        .game_over   (game_over),
        .board_clr   (board_clr),
        .match_done  (match_done),
        .match_winner(match_winner)
    );

    // {score_x, score_o, score_draw, last_result, game_over, board_clr, match_done, match_winner}
    logic [12:0] act;
    assign act = {score_x, score_o, score_draw, last_result,
                  game_over, board_clr, match_done, match_winner};

    typedef struct {
        logic [12:0] v;
        int          at;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    logic [1:0] ex_sx = '0, ex_so = '0, ex_sd = '0, ex_lr = '0, ex_mw = '0;
    logic       ex_go = 1'b0, ex_bc = 1'b0, ex_md = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input string tag, input int d);
        exp_t e;
        e.v   = {ex_sx, ex_so, ex_sd, ex_lr, ex_go, ex_bc, ex_md, ex_mw};
        e.at  = cyc + d;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cells(input logic [17:0] c);
        for (int i = 0; i < 9; i++) pos[i] = c[2*i +: 2];
    endtask

    // Applies a game result and predicts the count, then either the match
    // decision or the board_clr pulse five edges after RESULT entry.
    task automatic result_game(input logic [1:0] w, input logic [17:0] c,
                               input logic [1:0] sx, input logic [1:0] so,
                               input logic [1:0] sd, input logic [1:0] lr,
                               input bit mt, input string tag);
        win = w;
        set_cells(c);
        ex_sx = sx; ex_so = so; ex_sd = sd; ex_lr = lr; ex_go = 1'b1;
        push({tag, "_count"}, 1);
        if (mt) begin
            ex_md = 1'b1;
            ex_mw = w;
            push({tag, "_match"}, 2);
            step(3);
        end else begin
            ex_bc = 1'b1;
            push({tag, "_clr_on"}, 6);
            ex_bc = 1'b0;
            push({tag, "_clr_off"}, 7);
            step(8);
        end
    endtask

    task automatic clear_board(input string tag);
        win = 2'b00;
        set_cells(EMPTY);
        ex_go = 1'b0;
        push(tag, 1);
        step(2);
    endtask

    task automatic pulse_new_match(input string tag);
        new_match = 1'b1;
        ex_sx = '0; ex_so = '0; ex_sd = '0; ex_lr = '0; ex_mw = '0;
        ex_md = 1'b0; ex_go = 1'b1; ex_bc = 1'b1;
        push({tag, "_clr_on"}, 1);
        ex_bc = 1'b0;
        push({tag, "_clr_off"}, 2);
        step(1);
        new_match = 1'b0;
        step(2);
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    endtask

    // Monitor: one comparison per observed change of the output bundle.
    initial begin
        logic [12:0] prev;
        bit          first;
        exp_t        e;
        first = 1'b1;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (first || act !== prev) begin
                first = 1'b0;
                n_vec++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: got %b at cycle %0d, required no change from %b",
                             act, cyc, prev);
                end else begin
                    e = q.pop_front();
                    if (act !== e.v || cyc != e.at) begin
                        n_bad++;
                        $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                                 e.tag, act, cyc, e.v, e.at);
                    end
                end
            end
            prev = act;
        end
    end

    initial begin
        #100000;
        n_vec++;
        n_bad++;
        $display("FAIL watchdog: got time %0t, required finish before it", $time);
        summary();
        $finish;
    end

    initial begin
        rst       = 1'b1;
        win       = 2'b01;
        new_match = 1'b0;
        set_cells(EMPTY);
        push("reset", 1);
        step(2);
        rst = 1'b0;

        // First win straight after reset, then clear.
        result_game(2'b01, X_ROW, 2'd1, 2'd0, 2'd0, 2'b01, 1'b0, "x_win1");
        clear_board("x_win1_play");

        // 0 win held well past board_clr, then win cleared with cells still set.
        result_game(2'b10, O_ROW, 2'd1, 2'd1, 2'd0, 2'b10, 1'b0, "o_held");
        step(3);
        win = 2'b00;
        step(3);
        clear_board("o_held_play");

        // Invalid win code on a full board is ignored.
        win = 2'b11;
        set_cells(FULL);
        step(4);
        win = 2'b00;
        set_cells(EMPTY);
        step(2);

        result_game(2'b00, FULL, 2'd1, 2'd1, 2'd1, 2'b11, 1'b0, "draw1");
        clear_board("draw1_play");
        result_game(2'b01, X_ROW, 2'd2, 2'd1, 2'd1, 2'b01, 1'b0, "x_win2");
        clear_board("x_win2_play");
        result_game(2'b01, X_ROW, 2'd3, 2'd1, 2'd1, 2'b01, 1'b1, "x_win3");

        // Match decided: further wins and board activity change nothing.
        step(4);
        win = 2'b00;
        set_cells(EMPTY);
        step(2);
        win = 2'b01;
        set_cells(X_ROW);
        step(3);

        pulse_new_match("nm_after_match");
        clear_board("nm_after_match_play");

        // new_match and a win in the same PLAY cycle: the win is dropped.
        win = 2'b01;
        set_cells(X_ROW);
        pulse_new_match("nm_with_win");
        clear_board("nm_with_win_play");

        // Draw counter saturates at 3 with a 2-bit width.
        result_game(2'b00, FULL, 2'd0, 2'd0, 2'd1, 2'b11, 1'b0, "sat1");
        clear_board("sat1_play");
        result_game(2'b00, FULL, 2'd0, 2'd0, 2'd2, 2'b11, 1'b0, "sat2");
        clear_board("sat2_play");
        result_game(2'b00, FULL, 2'd0, 2'd0, 2'd3, 2'b11, 1'b0, "sat3");
        clear_board("sat3_play");
        result_game(2'b00, FULL, 2'd0, 2'd0, 2'd3, 2'b11, 1'b0, "sat4");
        clear_board("sat4_play");
        result_game(2'b00, FULL, 2'd0, 2'd0, 2'd3, 2'b11, 1'b0, "sat5");
        clear_board("sat5_play");

        step(3);
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_changes: got %0d predicted changes never seen (first %s), required 0",
                     q.size(), q[0].tag);
        end
        summary();
        $finish;
    end

endmodule
